ef_capture_sched: RTL and testbench



---
 rtl/ef_capture_sched.sv | 250 +++++++++++++++++++++++++
 tb/tb_ef_capture_sched.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ef_capture_sched.sv
// ef_capture_sched
//
// Capture-window scheduler for ef_capture_core. Runs one capture session:
// clears the BRAM address and frame counter through the core handshake, waits
// for a start time on the ATS reference counter, captures until a duration,
// frame budget, BRAM-full or abort condition, then stops the core and reports
// why.
//
// Ports:
//   clk                  clock, same domain as the capture core
//   rstn                 asynchronous active-low reset
//   reference_counter    ATS scheduler timer
//   i_ctrl               [0] arm (rising edge), [1] abort (rising edge),
//                        [2] immediate start (level, sampled in WAIT_START)
//   i_start_time         reference_counter value at which capture starts
//   i_duration           capture length in ticks, 0 = unlimited
//   i_max_frames         frame budget, 0 = unlimited
//   o_core_command       to core i_command, bits [2:0] only
//   i_core_status        from core o_status: [0] stopped, [1] ena_reset_done,
//                        [2] framecounter_reset_done, [3] stop_done
//   i_core_frame_counter from core o_frame_counter
//   o_sched_status       [3:0] state, [5:4] stop reason, [8] busy, [9] error
//   o_start_stamp        reference_counter latched on RUN entry
//   o_done               one-cycle pulse on entry to DONE or ERROR
//
// Build option: define EF_CAPTURE_SCHED_TIMEOUT_EN to bound every core
// handshake wait by HANDSHAKE_TIMEOUT cycles (expiry -> ERROR state).

module ef_capture_sched #(
  parameter int unsigned HANDSHAKE_TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] reference_counter,
  input  logic [31:0] i_ctrl,
  input  logic [31:0] i_start_time,
  input  logic [31:0] i_duration,
  input  logic [31:0] i_max_frames,
  output logic [31:0] o_core_command,
  input  logic [31:0] i_core_status,
  input  logic [31:0] i_core_frame_counter,
  output logic [31:0] o_sched_status,
  output logic [31:0] o_start_stamp,
  output logic        o_done
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CLR       = 4'd1,
    S_CLR_WAIT  = 4'd2,
    S_WAIT_START= 4'd3,
    S_RUN       = 4'd4,
    S_STOP      = 4'd5,
    S_STOP_WAIT = 4'd6,
    S_DONE      = 4'd7,
    S_ERROR     = 4'd8
  } state_t;

  localparam logic [1:0] RSN_DURATION = 2'd0;
  localparam logic [1:0] RSN_FRAMES   = 2'd1;
  localparam logic [1:0] RSN_FULL     = 2'd2;
  localparam logic [1:0] RSN_ABORT    = 2'd3;

  state_t      state_q, state_d;
  logic [1:0]  ctrl_prev_q;
  logic [1:0]  reason_q, reason_d;
  logic        err_q, err_d;
  logic        abort_lat_q, abort_lat_d;
  logic        seen_low_q, seen_low_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [31:0] stamp_q, stamp_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic        arm_rise, abort_rise;
  logic        clr_ready, stop_ready, core_stopped;
  logic signed [31:0] start_diff;
  logic [31:0] elapsed;
  logic        tmo_hit;

  assign arm_rise     = i_ctrl[0] & ~ctrl_prev_q[0];
  assign abort_rise   = i_ctrl[1] & ~ctrl_prev_q[1];
  assign core_stopped = i_core_status[0];
  assign clr_ready    = i_core_status[1] & i_core_status[2];
  assign stop_ready   = i_core_status[3];

  // Signed difference makes the start compare wrap-safe within +/- 2^31 ticks.
  assign start_diff = $signed(reference_counter - i_start_time);
  // Unsigned modulo-2^32 elapsed time since RUN entry.
  assign elapsed    = reference_counter - stamp_q;

  logic unused_bits;
  assign unused_bits = ^{i_ctrl[31:3], i_core_status[31:4]};

`ifdef EF_CAPTURE_SCHED_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        hs_wait;

  assign hs_wait = (state_q == S_CLR) || (state_q == S_CLR_WAIT) ||
                   (state_q == S_STOP) || (state_q == S_STOP_WAIT);
  assign tmo_hit = hs_wait && (tmo_cnt_q == 32'(HANDSHAKE_TIMEOUT - 1));

  // Counts cycles spent in the current handshake state; restarts on entry.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tmo_cnt_q <= '0;
    end else if (state_d != state_q) begin
      tmo_cnt_q <= '0;
    end else if (hs_wait) begin
      tmo_cnt_q <= tmo_cnt_q + 32'd1;
    end
  end
`else
  // Handshake waits are unbounded in this build; the parameter is inert.
  assign tmo_hit = 1'b0 && (HANDSHAKE_TIMEOUT != 0);
`endif

  always_comb begin
    state_d     = state_q;
    reason_d    = reason_q;
    err_d       = err_q;
    abort_lat_d = abort_lat_q;
    seen_low_d  = seen_low_q;
    cmd_d       = 3'b000;
    stamp_d     = stamp_q;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (arm_rise) begin
          state_d     = S_CLR;
          reason_d    = RSN_DURATION;
          err_d       = 1'b0;
          abort_lat_d = 1'b0;
          seen_low_d  = 1'b0;
        end
      end
      S_CLR: begin
        if (abort_rise) abort_lat_d = 1'b1;
        if (clr_ready) begin
          cmd_d      = 3'b011;
          state_d    = S_CLR_WAIT;
          seen_low_d = 1'b0;
        end
      end
      S_CLR_WAIT: begin
        if (abort_rise) abort_lat_d = 1'b1;
        // The core acknowledges by dropping a done flag, then raising both.
        if (!clr_ready) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          if (abort_lat_q || abort_rise) begin
            state_d  = S_DONE;
            reason_d = RSN_ABORT;
            done_d   = 1'b1;
          end else begin
            state_d = S_WAIT_START;
          end
        end
      end
      S_WAIT_START: begin
        // Abort before capture starts leaves the core enabled: no stop issued.
        if (abort_rise) begin
          state_d  = S_DONE;
          reason_d = RSN_ABORT;
          done_d   = 1'b1;
        end else if (i_ctrl[2] || (start_diff >= 0)) begin
          state_d = S_RUN;
          stamp_d = reference_counter;
        end
      end
      S_RUN: begin
        if (core_stopped) begin
          state_d  = S_DONE;
          reason_d = RSN_FULL;
          done_d   = 1'b1;
        end else if (abort_rise) begin
          state_d  = S_STOP;
          reason_d = RSN_ABORT;
        end else if ((i_max_frames != 32'd0) && (i_core_frame_counter >= i_max_frames)) begin
          state_d  = S_STOP;
          reason_d = RSN_FRAMES;
        end else if ((i_duration != 32'd0) && (elapsed >= i_duration)) begin
          state_d  = S_STOP;
          reason_d = RSN_DURATION;
        end
      end
      S_STOP: begin
        if (stop_ready) begin
          cmd_d      = 3'b100;
          state_d    = S_STOP_WAIT;
          seen_low_d = 1'b0;
        end
      end
      S_STOP_WAIT: begin
        if (!stop_ready) begin
          seen_low_d = 1'b1;
        end else if (seen_low_q) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled handshake overrides the wait; a real transition wins the tie.
    if (tmo_hit && (state_d == state_q)) begin
      state_d = S_ERROR;
      err_d   = 1'b1;
      done_d  = 1'b1;
      cmd_d   = 3'b000;
    end

    busy_d = (state_d == S_CLR) || (state_d == S_CLR_WAIT) ||
             (state_d == S_WAIT_START) || (state_d == S_RUN) ||
             (state_d == S_STOP) || (state_d == S_STOP_WAIT);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      ctrl_prev_q <= 2'b00;
      reason_q    <= 2'b00;
      err_q       <= 1'b0;
      abort_lat_q <= 1'b0;
      seen_low_q  <= 1'b0;
      cmd_q       <= 3'b000;
      stamp_q     <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_prev_q <= i_ctrl[1:0];
      reason_q    <= reason_d;
      err_q       <= err_d;
      abort_lat_q <= abort_lat_d;
      seen_low_q  <= seen_low_d;
      cmd_q       <= cmd_d;
      stamp_q     <= stamp_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
    end
  end

  assign o_core_command = {29'd0, cmd_q};
  assign o_sched_status = {22'd0, err_q, busy_q, 2'b00, reason_q, state_q};
  assign o_start_stamp  = stamp_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_ef_capture_sched.sv
// Directed self-checking bench for ef_capture_sched with a small behavioural
// model of the capture core's command/status handshake.

module tb_ef_capture_sched;

  logic        clk = 1'b0;
  logic        rstn;
  logic [31:0] reference_counter, i_ctrl, i_start_time, i_duration, i_max_frames;
  logic [31:0] i_core_status, i_core_frame_counter;
  logic [31:0] o_core_command, o_sched_status, o_start_stamp;
  logic        o_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ef_capture_sched #(.HANDSHAKE_TIMEOUT(16)) dut (
    .clk                 (clk),
    .rstn                (rstn),
    .reference_counter   (reference_counter),
    .i_ctrl              (i_ctrl),
    .i_start_time        (i_start_time),
    .i_duration          (i_duration),
    .i_max_frames        (i_max_frames),
    .o_core_command      (o_core_command),
    .i_core_status       (i_core_status),
    .i_core_frame_counter(i_core_frame_counter),
    .o_sched_status      (o_sched_status),
    .o_start_stamp       (o_start_stamp),
    .o_done              (o_done)
  );

  // Core model: done flags drop for two cycles after a command is seen.
  logic        st_ena, st_fc, st_stop, stopped;
  logic [1:0]  clr_cnt, stop_cnt;
  logic [31:0] frames;
  logic        send_frame, force_full, hold_stop_low;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_ena <= 1'b1; st_fc <= 1'b1; st_stop <= 1'b1; stopped <= 1'b1;
      clr_cnt <= 2'd0; stop_cnt <= 2'd0; frames <= 32'd0;
    end else begin
      if (o_core_command[1:0] == 2'b11) begin
        st_ena <= 1'b0; st_fc <= 1'b0; clr_cnt <= 2'd2; frames <= 32'd0; stopped <= 1'b0;
      end else begin
        if (clr_cnt != 2'd0) clr_cnt <= clr_cnt - 2'd1;
        if (clr_cnt == 2'd1) begin st_ena <= 1'b1; st_fc <= 1'b1; end
        if (send_frame) frames <= frames + 32'd1;
      end
      if (o_core_command[2]) begin
        st_stop <= 1'b0; stop_cnt <= 2'd2; stopped <= 1'b1;
      end else begin
        if (stop_cnt != 2'd0) stop_cnt <= stop_cnt - 2'd1;
        if (stop_cnt == 2'd1) st_stop <= 1'b1;
      end
    end
  end

  assign i_core_status        = {28'd0, st_stop & ~hold_stop_low, st_fc, st_ena, stopped | force_full};
  assign i_core_frame_counter = frames;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    reference_counter = reference_counter + 32'd1;
  endtask

  function automatic logic [31:0] st_now();
    return {28'd0, o_sched_status[3:0]};
  endfunction

  function automatic logic [31:0] reason_now();
    return {30'd0, o_sched_status[5:4]};
  endfunction

  task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
    int n = 0;
    while ((o_sched_status[3:0] != s) && (n < budget)) begin
      tick();
      n++;
    end
    check(tag, st_now(), {28'd0, s});
  endtask

  // Waits for a command pulse, checks its value and that it lasts one cycle.
  task automatic wait_cmd(input logic [2:0] exp, input string tag);
    int n = 0;
    while ((o_core_command == 32'd0) && (n < 20)) begin
      tick();
      n++;
    end
    check(tag, o_core_command, {29'd0, exp});
    tick();
    check({tag, "_len"}, o_core_command, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0; reference_counter = 32'd0; i_ctrl = 32'd0; i_start_time = 32'd0;
    i_duration = 32'd0; i_max_frames = 32'd0;
    send_frame = 1'b0; force_full = 1'b0; hold_stop_low = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state",  st_now(),        32'd0);
    check("rst_cmd",    o_core_command,  32'd0);
    check("rst_status", o_sched_status,  32'd0);
    check("rst_stamp",  o_start_stamp,   32'd0);
    check("rst_done",   {31'd0, o_done}, 32'd0);
    rstn = 1'b1;
    tick();

    // Immediate start, frame budget of 3
    i_max_frames = 32'd3; i_duration = 32'd0;
    i_ctrl = 32'h5;
    tick();
    check("t1_arm_clr", st_now(), 32'd1);
    check("t1_no_early_cmd", o_core_command, 32'd0);
    i_ctrl = 32'h4;
    wait_cmd(3'b011, "t1_clr_cmd");
    wait_state(4'd4, 20, "t1_run");
    check("t1_busy", {31'd0, o_sched_status[8]}, 32'd1);
    send_frame = 1'b1;
    repeat (3) tick();
    send_frame = 1'b0;
    tick();
    check("t1_stop", st_now(), 32'd5);
    check("t1_reason_stop", reason_now(), 32'd1);
    wait_cmd(3'b100, "t1_stop_cmd");
    wait_state(4'd7, 20, "t1_done");
    check("t1_done_pulse", {31'd0, o_done}, 32'd1);
    check("t1_reason", reason_now(), 32'd1);
    check("t1_core_stopped", {31'd0, i_core_status[0]}, 32'd1);
    check("t1_not_busy", {31'd0, o_sched_status[8]}, 32'd0);
    tick();
    check("t1_done_once", {31'd0, o_done}, 32'd0);

    // Timed start across counter wrap, then duration stop
    i_max_frames = 32'd0; i_duration = 32'd100; i_start_time = 32'h0000_0010;
    i_ctrl = 32'h1;
    tick();
    i_ctrl = 32'h0;
    wait_state(4'd3, 20, "t2_wait_start");
    reference_counter = 32'hFFFF_FFF0;
    repeat (32) tick();
    check("t2_wait_held", st_now(), 32'd3);
    tick();
    check("t2_run", st_now(), 32'd4);
    check("t2_stamp", o_start_stamp, 32'h0000_0010);
    repeat (99) tick();
    check("t2_dur_run", st_now(), 32'd4);
    tick();
    check("t2_dur_stop", st_now(), 32'd5);
    check("t2_dur_reason", reason_now(), 32'd0);
    wait_cmd(3'b100, "t2_stop_cmd");
    wait_state(4'd7, 20, "t2_done");
    check("t2_reason", reason_now(), 32'd0);

    // BRAM full in RUN; arm ignored while running
    i_duration = 32'd0;
    i_ctrl = 32'h5;
    tick();
    i_ctrl = 32'h4;
    wait_state(4'd4, 20, "t3_run");
    i_ctrl = 32'h5;
    tick();
    i_ctrl = 32'h4;
    check("t3_arm_ignored", st_now(), 32'd4);
    force_full = 1'b1;
    tick();
    check("t3_done", st_now(), 32'd7);
    check("t3_reason", reason_now(), 32'd2);
    check("t3_done_pulse", {31'd0, o_done}, 32'd1);
    check("t3_no_cmd", o_core_command, 32'd0);
    force_full = 1'b0;
    tick();
    check("t3_done_once", {31'd0, o_done}, 32'd0);
    check("t3_hold", st_now(), 32'd7);
    check("t3_no_cmd2", o_core_command, 32'd0);

    // Abort during CLR_WAIT
    i_ctrl = 32'h1;
    tick();
    i_ctrl = 32'h0;
    tick();
    check("t4_clr_wait", st_now(), 32'd2);
    i_ctrl = 32'h2;
    tick();
    i_ctrl = 32'h0;
    wait_state(4'd7, 20, "t4_done");
    check("t4_reason", reason_now(), 32'd3);
    check("t4_clear_done", {29'd0, i_core_status[2:0]}, 32'h6);

    // Abort in WAIT_START: no stop command, core left enabled
    i_start_time = reference_counter + 32'd10000;
    i_ctrl = 32'h1;
    tick();
    i_ctrl = 32'h0;
    wait_state(4'd3, 20, "t5_wait_start");
    i_ctrl = 32'h2;
    tick();
    i_ctrl = 32'h0;
    check("t5_done", st_now(), 32'd7);
    check("t5_reason", reason_now(), 32'd3);
    check("t5_done_pulse", {31'd0, o_done}, 32'd1);
    check("t5_no_cmd", o_core_command, 32'd0);
    tick();
    check("t5_core_running", {31'd0, i_core_status[0]}, 32'd0);

    // Stalled stop handshake
    i_ctrl = 32'h5;
    tick();
    i_ctrl = 32'h4;
    wait_state(4'd4, 20, "t6_run");
    hold_stop_low = 1'b1;
    i_ctrl = 32'h6;
    tick();
    i_ctrl = 32'h4;
    check("t6_stop", st_now(), 32'd5);
    check("t6_reason", reason_now(), 32'd3);
`ifdef EF_CAPTURE_SCHED_TIMEOUT_EN
    repeat (15) tick();
    check("t6_still_stop", st_now(), 32'd5);
    tick();
    check("t6_error", st_now(), 32'd8);
    check("t6_error_bit", {31'd0, o_sched_status[9]}, 32'd1);
    check("t6_err_done", {31'd0, o_done}, 32'd1);
    check("t6_err_cmd", o_core_command, 32'd0);
    check("t6_err_busy", {31'd0, o_sched_status[8]}, 32'd0);
    hold_stop_low = 1'b0;
    i_ctrl = 32'h1;
    tick();
    i_ctrl = 32'h0;
    check("t6_rearm", st_now(), 32'd1);
    check("t6_err_clear", {31'd0, o_sched_status[9]}, 32'd0);
`else
    repeat (40) tick();
    check("t6_unbounded", st_now(), 32'd5);
    check("t6_no_error", {31'd0, o_sched_status[9]}, 32'd0);
    hold_stop_low = 1'b0;
    wait_cmd(3'b100, "t6_stop_cmd");
    wait_state(4'd7, 20, "t6_done");
    check("t6_final_reason", reason_now(), 32'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
